// File: rtl/fmulby3_pkg.sv
// Shared types and constants for the fmulby3 clock-enable frequency multiplier.
package fmulby3_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle,
        StMeasure,
        StRun
    } state_e;

    // The prescaler reports a wrap while sitting in this state (2 -> 0 transition).
    localparam int unsigned PrescWrap   = 2;
    localparam int unsigned PrescStates = PrescWrap + 1;

endpackage

// File: rtl/mod3_prescaler.sv
// One-hot modulo-3 prescaler: o_wrap is high in the cycle whose rising edge moves the
// count from 2 back to 0. i_restart forces the count to 0 on the next edge.
module mod3_prescaler
    import fmulby3_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_wrap
);

    logic [PrescStates-1:0] r_oh;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            r_oh <= PrescStates'(1);
        end else begin
            r_oh <= {r_oh[PrescStates-2:0], r_oh[PrescStates-1]};
        end
    end

    assign o_wrap = r_oh[PrescWrap];

endmodule

// File: rtl/fmulby3.sv
// Clock-enable frequency multiplier by 3: measures the tick_in spacing and emits three
// evenly spaced one-cycle pulses per input period. FMULBY3_PERIOD_EN adds o_interval.
module fmulby3
    import fmulby3_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_tick_in,
    output logic         o_tick_out,
    output logic         o_locked
`ifdef FMULBY3_PERIOD_EN
    ,
    output logic [W-1:0] o_interval
`endif
);

    localparam int unsigned PW = W + 1;
    localparam logic [W-1:0] QMax = '1;

    state_e        r_state;
    state_e        w_state_d;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_i;
    logic          r_ovf;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] r_target;
    logic [1:0]    r_left;
    logic          r_tick_out;

    logic          w_clear;
    logic          w_tick;
    logic          w_wrap;
    logic          w_ovf_now;
    logic          w_ovf_any;
    logic [W-1:0]  w_q_next;
    logic          w_i_zero;
    logic [PW-1:0] w_phase_inc;
    logic [PW-1:0] w_phase_d;
    logic [PW-1:0] w_target_d;
    logic [1:0]    w_left_d;
    logic          w_fire;

    // clr shares the reset effect and also swallows a coincident tick.
    assign w_clear = i_rst | i_clr;
    assign w_tick  = i_tick_in & ~w_clear;

    mod3_prescaler u_presc (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (i_clr | i_tick_in),
        .o_wrap    (w_wrap)
    );

    // q + wrap is floor(P/3) when sampled on the tick edge; it saturates at QMax.
    assign w_ovf_now = w_wrap & (r_q == QMax);
    assign w_q_next  = w_ovf_now ? r_q : r_q + W'(w_wrap);
    assign w_ovf_any = r_ovf | w_ovf_now;
    assign w_i_zero  = (w_q_next == '0);

    always_comb begin
        w_state_d = r_state;
        if (w_tick) begin
            case (r_state)
                StIdle:            w_state_d = StMeasure;
                StMeasure, StRun:  w_state_d = (w_ovf_any || w_i_zero) ? StMeasure : StRun;
                default:           w_state_d = StIdle;
            endcase
        end else if (w_ovf_now && (r_state == StRun)) begin
            w_state_d = StMeasure;
        end
    end

    assign w_phase_inc = r_phase + PW'(1);

    // Pulse at phase 0 (the tick edge), then when the phase reaches I and 2I.
    always_comb begin
        w_phase_d  = r_phase;
        w_target_d = r_target;
        w_left_d   = r_left;
        w_fire     = 1'b0;
        if (w_tick) begin
            w_phase_d  = '0;
            w_target_d = {1'b0, w_q_next};
            w_fire     = (w_state_d == StRun);
            w_left_d   = w_fire ? 2'd2 : 2'd0;
        end else if (w_state_d != StRun) begin
            w_left_d = 2'd0;
        end else if (r_left != 2'd0) begin
            w_phase_d = w_phase_inc;
            if (w_phase_inc == r_target) begin
                w_fire     = 1'b1;
                w_target_d = r_target + {1'b0, r_i};
                w_left_d   = r_left - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_state    <= StIdle;
            r_q        <= '0;
            r_i        <= '0;
            r_ovf      <= 1'b0;
            r_phase    <= '0;
            r_target   <= '0;
            r_left     <= 2'd0;
            r_tick_out <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_phase    <= w_phase_d;
            r_target   <= w_target_d;
            r_left     <= w_left_d;
            r_tick_out <= w_fire;
            if (w_tick) begin
                r_q   <= '0;
                r_i   <= w_q_next;
                r_ovf <= 1'b0;
            end else begin
                r_q   <= w_q_next;
                r_ovf <= w_ovf_any;
            end
        end
    end

    assign o_tick_out = r_tick_out;
    assign o_locked   = (r_state == StRun);

`ifdef FMULBY3_PERIOD_EN
    assign o_interval = r_i;
`endif

endmodule

// File: tb/tb_fmulby3.sv
// Directed bench for fmulby3: a W=16 and a W=4 instance share stimulus; the W=4 one is
// checked across the overflow section.
module tb_fmulby3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic tick = 1'b0;
    logic t16, l16, t4, l4;
    logic sel4 = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

`ifdef FMULBY3_PERIOD_EN
    logic [15:0] iv16;
    logic [3:0]  iv4;
`endif

    always #5 clk = ~clk;

    fmulby3 #(.W(16)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (clr),
        .i_tick_in  (tick),
        .o_tick_out (t16),
        .o_locked   (l16)
`ifdef FMULBY3_PERIOD_EN
        ,
        .o_interval (iv16)
`endif
    );

    fmulby3 #(.W(4)) dut4 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (clr),
        .i_tick_in  (tick),
        .o_tick_out (t4),
        .o_locked   (l4)
`ifdef FMULBY3_PERIOD_EN
        ,
        .o_interval (iv4)
`endif
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // One input period of length p starting with a tick (plus clr if c). Pulses are
    // expected at offsets a, b, c_off (1 = cycle after the tick edge; 0 = unused).
    // locked is expected lk, falling from offset drop onward when drop != 0.
    task automatic period(input string tag, input int p, input int a, input int b,
                          input int c_off, input logic lk, input int drop, input bit c);
        logic exp_t, exp_l, obs_t, obs_l;
        for (int j = 0; j < p; j++) begin
            tick = (j == 0);
            clr  = c && (j == 0);
            @(posedge clk);
            #1;
            tick  = 1'b0;
            clr   = 1'b0;
            exp_t = (j + 1 == a) || (j + 1 == b) || (j + 1 == c_off);
            exp_l = lk && ((drop == 0) || (j + 1 < drop));
            obs_t = sel4 ? t4 : t16;
            obs_l = sel4 ? l4 : l16;
            chk($sformatf("%s tick_out @+%0d", tag, j + 1), obs_t, exp_t);
            chk($sformatf("%s locked @+%0d", tag, j + 1), obs_l, exp_l);
        end
    endtask

    initial begin
        // Reset held: outputs zero from the first edge.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("reset tick_out %0d", k), t16, 1'b0);
            chk($sformatf("reset locked %0d", k), l16, 1'b0);
            chk($sformatf("reset4 tick_out %0d", k), t4, 1'b0);
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle tick_out %0d", k), t16, 1'b0);
            chk($sformatf("idle locked %0d", k), l16, 1'b0);
        end

        period("first",  9, 0, 0, 0, 1'b0, 0, 1'b0);  // IDLE -> MEASURE
        period("p9a",    9, 1, 4, 7, 1'b1, 0, 1'b0);  // I=3, locks
        period("p9b",   10, 1, 4, 7, 1'b1, 0, 1'b0);
        period("p10a",  10, 1, 4, 7, 1'b1, 0, 1'b0);  // P=10 -> I=3, idle gap at +10
        period("p10b",   9, 1, 4, 7, 1'b1, 0, 1'b0);
        period("early",  5, 1, 4, 0, 1'b1, 0, 1'b0);  // aborted before +7
        period("i1",     9, 1, 2, 3, 1'b1, 0, 1'b0);  // P=5 -> I=1
        period("short",  2, 1, 0, 0, 1'b1, 0, 1'b0);  // P=9 -> I=3, cut after 2
        period("izero",  9, 0, 0, 0, 1'b0, 0, 1'b0);  // P=2 -> I=0, drop
        period("relock", 9, 1, 4, 7, 1'b1, 0, 1'b0);
        period("steady", 9, 1, 4, 7, 1'b1, 0, 1'b0);

        // W=4: q saturates 48 cycles into a 60-cycle period.
        sel4 = 1'b1;
        period("ovf",    60, 1, 4, 7, 1'b1, 49, 1'b0);
        period("ovfmeas", 9, 0, 0, 0, 1'b0, 0, 1'b0);
        period("ovfrelk", 9, 1, 4, 7, 1'b1, 0, 1'b0);
        sel4 = 1'b0;

        period("clr",     9, 0, 0, 0, 1'b0, 0, 1'b1);  // clr beats coincident tick
        period("clrmeas", 9, 0, 0, 0, 1'b0, 0, 1'b0);
        period("clrrelk", 9, 1, 4, 7, 1'b1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fmulby3.md
# fmulby3

Clock-enable frequency multiplier by 3; the counterpart of the divide-by-3 counter in the same lab. It measures the spacing of incoming one-cycle `tick_in` pulses and regenerates three evenly spaced `tick_out` pulses per input period. It sits in the same `clk` domain, downstream of a slow enable source, and feeds blocks that need a 3x-rate enable.

## Interface
- `W`, default 16: width of the interval counter; the maximum measurable interval is 2^W-1.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `clr`  input  1  synchronous clear. Same effect as `rst`; lower priority than `rst`.
- `tick_in`  input  1  slow enable pulse, one cycle wide.
- `tick_out`  output  1  3x enable pulse, one cycle wide, registered.
- `locked`  output  1  high while the period is valid and pulses are being generated.

## Operation
- **Measurement**
  - P = number of `clk` edges between two consecutive sampled `tick_in` pulses.
  - I = floor(P/3), produced with no divider: the `mod3_prescaler` wraps 0→1→2→0 every cycle; each wrap increments counter `q`.
  - On `tick_in`: latch I = `q`, then restart the prescaler and `q` from 0.
- **FSM states: IDLE, MEASURE, RUN**
  - IDLE: no tick seen yet. `tick_in` → MEASURE.
  - MEASURE: first period in progress. On `tick_in`: if I ≥ 1 → RUN, else stay in MEASURE.
  - RUN: at each `tick_in`, relatch I and restart the emission schedule.
  - RUN with I = 0 (P < 3): drop to MEASURE and emit no pulse for that period.
- **Emission (RUN only)**
  - A phase counter restarts at every `tick_in`.
  - `tick_out` fires at offsets 0, I and 2I, using the I just latched.
- **Early `tick_in`:** a new `tick_in` arriving before the third pulse aborts the remaining pulses. The new schedule starts immediately; pulses are never merged or queued.
- **Overflow:** if `q` would pass 2^W-1, it saturates and the FSM moves to MEASURE at once (`locked` falls). The next `tick_in` restarts the measurement.
- **`clr` / `rst`:** return to IDLE and zero `q`, the prescaler, the phase counter and I. `clr` together with `tick_in` in the same cycle: `clr` wins and `tick_in` is ignored.
- **Reset values:** `tick_out`=0, `locked`=0.
- **`locked`:** equals (state == RUN), registered.

## Timing
- Latency is 1 cycle: `tick_in` sampled at edge t gives `tick_out` high in cycle t+1, then t+1+I and t+1+2I.
- Example P=9 → I=3: pulses at t+1, t+4, t+7. The next `tick_in` at t+9 gives a pulse at t+10.
- Example P=10 → I=3: same pulses, with one idle gap cycle before the next period.
- `locked` rises in the cycle after the second `tick_in`, together with the first `tick_out`.
- `locked` falls one cycle after an overflow or an I=0 detection.
- With `rst` held, outputs are 0 from the first edge on.

## Configuration
- **`FMULBY3_PERIOD_EN`**
  - Defined: adds output port `interval` [W-1:0], carrying the latched I (reset 0, updated at each `tick_in`).
  - Undefined: the port and its register are absent.
  - Pulse behaviour is identical in both builds.

## Structure
- **Package `fmulby3_pkg`:** state enum (IDLE, MEASURE, RUN), state width, prescaler wrap constant 2.
- **Sub-module `mod3_prescaler`:**
  - Ports: `clk`, `rst`, `restart`, output `wrap`.
  - Runs a 3-state one-hot count and pulses `wrap` on the 2→0 transition.
- **Top level:** `q` counter, latch for I, phase counter, FSM, output register.

## Test plan
- Reset, then `tick_in` every 9 cycles → from the second tick, `tick_out` fires at +1, +4, +7. `locked`=1 after the second tick.
- `tick_in` every 10 cycles → I=3; pulses at +1, +4, +7; `locked` stays 1.
- Period 9 followed by a tick after only 5 cycles → the third pulse (+7) is suppressed and a new pulse comes at +1 of the new tick. The new I=1 then gives pulses at +1, +2, +3 next period.
- `tick_in` spacing 2 → I=0; `locked` drops, no `tick_out`. Spacing back to 9 → relocks after one full period.
- W=4 with spacing 60 → `q` overflows and `locked` falls mid-period; spacing back to 9 → relocks.
- `clr` asserted together with `tick_in` while in RUN → IDLE; `locked`=0, no `tick_out`. Two more ticks at spacing 9 are needed to relock.
